dcache_data_wr_ctrl: RTL and testbench



---
 rtl/dcache_data_wr_ctrl_if.sv | 44 ++++
 rtl/dcache_data_wr_ctrl.sv | 109 ++++++++++
 tb/tb_dcache_data_wr_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_data_wr_ctrl_if.sv
// Write-side signals of one D-cache data bank: store commit, AXI refill beats, RAM write port.
// master = store buffer / refill unit / bank side, slave = write controller.
interface dcache_data_wr_ctrl_if #(
  parameter int LINE  = 128,
  parameter int BLOCK = 8
);
  localparam int IW = $clog2(LINE);
  localparam int OW = $clog2(BLOCK);

  logic                  st_valid;
  logic                  st_ready;
  logic [IW-1:0]         st_index;
  logic [OW-1:0]         st_offset;
  logic [3:0]            st_wstrb;
  logic [31:0]           st_wdata;

  logic                  rf_start;
  logic [IW-1:0]         rf_index;
  logic                  rf_busy;
  logic                  rf_beat_valid;
  logic                  rf_beat_ready;
  logic [31:0]           rf_beat_data;
  logic                  rf_beat_last;
  logic                  rf_done;
  logic                  rf_err;

  logic [4*BLOCK-1:0]    ram_wen;
  logic [IW-1:0]         ram_windex;
  logic [32*BLOCK-1:0]   ram_wdata;

  modport master (
    output st_valid, st_index, st_offset, st_wstrb, st_wdata,
    output rf_start, rf_index, rf_beat_valid, rf_beat_data, rf_beat_last,
    input  st_ready, rf_busy, rf_beat_ready, rf_done, rf_err,
    input  ram_wen, ram_windex, ram_wdata
  );

  modport slave (
    input  st_valid, st_index, st_offset, st_wstrb, st_wdata,
    input  rf_start, rf_index, rf_beat_valid, rf_beat_data, rf_beat_last,
    output st_ready, rf_busy, rf_beat_ready, rf_done, rf_err,
    output ram_wen, ram_windex, ram_wdata
  );
endinterface

// File: rtl/dcache_data_wr_ctrl.sv
// Write-port sequencer for one D-cache data bank: merges store-commit words and refilled lines.
// RAM outputs registered (1 cycle); stores stall on the final refill beat and on the line under refill.
module dcache_data_wr_ctrl #(
  parameter int LINE  = 128,
  parameter int BLOCK = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  dcache_data_wr_ctrl_if.slave bus
);
  localparam int IW = $clog2(LINE);
  localparam int OW = $clog2(BLOCK);
  localparam int WW = 4 * BLOCK;
  localparam int DW = 32 * BLOCK;
  localparam logic [OW-1:0] LAST_BEAT = OW'(BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                 state_q;
  logic [OW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [BLOCK-1:0][31:0] buf_q;
  logic [WW-1:0]          ram_wen_q;
  logic [IW-1:0]          ram_windex_q;
  logic [DW-1:0]          ram_wdata_q;
  logic                   rf_done_q;
  logic                   rf_err_q;

  logic                   beat_hs;
  logic                   final_hs;
  logic                   hazard;
  logic                   st_fire;
  logic [BLOCK-1:0][31:0] line_d;
  logic [WW-1:0]          st_wen_d;

  always_comb begin
    beat_hs  = (state_q == FILL) && bus.rf_beat_valid;
    final_hs = beat_hs && (cnt_q == LAST_BEAT);
    // Keep stores off the line being refilled; the full-line write would clobber them.
    hazard   = ((state_q == FILL) && (bus.st_index == idx_q)) ||
               ((state_q == IDLE) && bus.rf_start && (bus.st_index == bus.rf_index));
    st_fire  = bus.st_valid && !final_hs && !hazard;
    line_d            = buf_q;
    line_d[BLOCK-1]   = bus.rf_beat_data;
    st_wen_d = {{(WW-4){1'b0}}, bus.st_wstrb} << {bus.st_offset, 2'b00};
  end

  assign bus.st_ready      = !final_hs && !hazard;
  assign bus.rf_busy       = (state_q != IDLE);
  assign bus.rf_beat_ready = (state_q == FILL);
  assign bus.rf_done       = rf_done_q;
  assign bus.rf_err        = rf_err_q;
  assign bus.ram_wen       = ram_wen_q;
  assign bus.ram_windex    = ram_windex_q;
  assign bus.ram_wdata     = ram_wdata_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      ram_wen_q    <= '0;
      ram_windex_q <= '0;
      ram_wdata_q  <= '0;
      rf_done_q    <= 1'b0;
      rf_err_q     <= 1'b0;
    end else begin
      ram_wen_q <= '0;
      rf_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.rf_start) begin
            idx_q   <= bus.rf_index;
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (beat_hs) begin
            // Only the beat count ends the line; a disagreeing last flag is just flagged.
            if (bus.rf_beat_last != (cnt_q == LAST_BEAT)) rf_err_q <= 1'b1;
            if (cnt_q == LAST_BEAT) begin
              cnt_q     <= '0;
              state_q   <= WRITE;
              rf_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (final_hs) begin
        ram_wen_q    <= '1;
        ram_windex_q <= idx_q;
        ram_wdata_q  <= line_d;
      end else if (st_fire) begin
        ram_wen_q    <= st_wen_d;
        ram_windex_q <= bus.st_index;
        ram_wdata_q  <= {BLOCK{bus.st_wdata}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_hs) buf_q[cnt_q] <= bus.rf_beat_data;
  end
endmodule

// File: tb/tb_dcache_data_wr_ctrl.sv
// Randomized and directed bench for dcache_data_wr_ctrl against a queue-based refill/store model.
// Inputs are driven at the falling edge; comb outputs checked before, registered outputs after the rising edge.
module tb_dcache_data_wr_ctrl;
  localparam int LINE  = 128;
  localparam int BLOCK = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dcache_data_wr_ctrl_if #(.LINE(LINE), .BLOCK(BLOCK)) bus ();
  dcache_data_wr_ctrl #(.LINE(LINE), .BLOCK(BLOCK)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  logic        d_resetn = 1'b0;
  logic        d_svalid = 1'b0;
  logic [6:0]  d_sidx = '0;
  logic [2:0]  d_soff = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_sdata = '0;
  logic        d_start = 1'b0;
  logic [6:0]  d_ridx = '0;
  logic        d_bvalid = 1'b0;
  logic [31:0] d_bdata = '0;
  logic        d_last = 1'b0;

  // Reference model: refill collected as a queue of beats
  bit          m_fill = 0;
  bit          m_wr = 0;
  logic [6:0]  m_idx = '0;
  logic [31:0] m_beats[$];
  bit          m_err = 0;
  logic [31:0]  e_wen = '0;
  logic [6:0]   e_widx = '0;
  logic [255:0] e_wdata = '0;
  bit           e_done = 0;
  bit           comb_en = 0;

  task automatic idle_inputs();
    d_resetn = 1'b1; d_svalid = 1'b0; d_start = 1'b0; d_bvalid = 1'b0; d_last = 1'b0;
  endtask

  task automatic tick();
    bit fin, haz, e_srdy, e_busy;
    @(negedge clk);
    resetn            = d_resetn;
    bus.st_valid      = d_svalid;
    bus.st_index      = d_sidx;
    bus.st_offset     = d_soff;
    bus.st_wstrb      = d_wstrb;
    bus.st_wdata      = d_sdata;
    bus.rf_start      = d_start;
    bus.rf_index      = d_ridx;
    bus.rf_beat_valid = d_bvalid;
    bus.rf_beat_data  = d_bdata;
    bus.rf_beat_last  = d_last;
    #1;
    e_busy = m_fill || m_wr;
    fin    = m_fill && d_bvalid && (m_beats.size() == BLOCK - 1);
    haz    = (m_fill && d_sidx == m_idx) || (!e_busy && d_start && d_sidx == d_ridx);
    e_srdy = !fin && !haz;
    if (comb_en) begin
      check("st_ready", bus.st_ready, e_srdy);
      check("rf_busy", bus.rf_busy, e_busy);
      check("rf_beat_ready", bus.rf_beat_ready, m_fill);
    end
    if (!d_resetn) begin
      m_fill = 0; m_wr = 0; m_err = 0; m_beats.delete();
      e_wen = '0; e_widx = '0; e_wdata = '0; e_done = 0;
    end else begin
      e_wen = '0; e_done = 0;
      if (m_wr) begin
        m_wr = 0;
      end else if (m_fill) begin
        if (d_bvalid) begin
          if (d_last != (m_beats.size() == BLOCK - 1)) m_err = 1;
          m_beats.push_back(d_bdata);
          if (m_beats.size() == BLOCK) begin
            e_wen = '1; e_widx = m_idx; e_done = 1;
            for (int w = 0; w < BLOCK; w++) e_wdata[32*w +: 32] = m_beats[w];
            m_beats.delete(); m_fill = 0; m_wr = 1;
          end
        end
      end else if (d_start) begin
        m_fill = 1; m_idx = d_ridx; m_beats.delete();
      end
      if (d_svalid && e_srdy) begin
        for (int b = 0; b < 4 * BLOCK; b++) e_wen[b] = ((b / 4) == int'(d_soff)) && d_wstrb[b % 4];
        e_widx = d_sidx;
        for (int w = 0; w < BLOCK; w++) e_wdata[32*w +: 32] = d_sdata;
      end
    end
    @(posedge clk);
    #1;
    check("ram_wen", bus.ram_wen, e_wen);
    check("ram_windex", bus.ram_windex, e_widx);
    check("ram_wdata", bus.ram_wdata, e_wdata);
    check("rf_done", bus.rf_done, e_done);
    check("rf_err", bus.rf_err, m_err);
    comb_en = 1;
  endtask

  initial begin
    int bi;
    int cyc;
    resetn = 1'b0;
    bus.st_valid = 0; bus.st_index = '0; bus.st_offset = '0; bus.st_wstrb = '0; bus.st_wdata = '0;
    bus.rf_start = 0; bus.rf_index = '0; bus.rf_beat_valid = 0; bus.rf_beat_data = '0; bus.rf_beat_last = 0;

    // Reset with store and refill start held
    d_resetn = 0; d_svalid = 1; d_sidx = 7'd3; d_wstrb = 4'hF; d_sdata = 32'h1234_5678;
    d_start = 1; d_ridx = 7'd4;
    repeat (3) tick();
    check("reset_busy", bus.rf_busy, 1'b0);
    check("reset_wen", bus.ram_wen, 32'h0);

    // Single store after reset
    idle_inputs();
    d_svalid = 1; d_sidx = 7'd5; d_soff = 3'd3; d_wstrb = 4'b0110; d_sdata = 32'hAABBCCDD;
    tick();
    check("store_wen", bus.ram_wen, 32'h0000_6000);
    check("store_idx", bus.ram_windex, 7'd5);
    check("store_word3", bus.ram_wdata[96 +: 32], 32'hAABBCCDD);

    // Refill of line 9 with toggled beat valid, stores alternating to 9 and 10
    idle_inputs();
    d_start = 1; d_ridx = 7'd9;
    tick();
    d_start = 0; d_svalid = 1; d_wstrb = 4'hF; d_soff = 3'd1;
    bi = 0; cyc = 0;
    while (bi < BLOCK && cyc < 100) begin
      d_bvalid = (cyc % 2 == 0);
      d_bdata  = 32'h100 + bi;
      d_last   = (bi == BLOCK - 1);
      d_sidx   = (cyc % 2 == 1) ? 7'd9 : 7'd10;
      d_sdata  = 32'h5000 + cyc;
      tick();
      if (d_bvalid) bi++;
      cyc++;
    end
    check("refill_beats", bi, BLOCK);
    check("line_done", bus.rf_done, 1'b1);
    check("line_wen", bus.ram_wen, 32'hFFFF_FFFF);
    check("line_idx", bus.ram_windex, 7'd9);
    for (int w = 0; w < BLOCK; w++) check("line_word", bus.ram_wdata[32*w +: 32], 32'h100 + w);
    check("line_err", bus.rf_err, 1'b0);
    d_bvalid = 0; d_last = 0; d_sidx = 7'd9; d_sdata = 32'hCAFE_0009;
    tick();
    check("post_done", bus.rf_done, 1'b0);
    check("late_store_idx", bus.ram_windex, 7'd9);
    check("late_store_wen", bus.ram_wen, 32'h0000_00F0);

    // Early last flag on beat 3: error sticks, line still needs 8 beats
    idle_inputs();
    d_start = 1; d_ridx = 7'd20;
    tick();
    d_start = 0;
    for (int i = 0; i < BLOCK; i++) begin
      d_bvalid = 1; d_bdata = $urandom; d_last = (i == 3);
      tick();
    end
    check("err_sticky", bus.rf_err, 1'b1);
    check("err_line_done", bus.rf_done, 1'b1);
    idle_inputs();
    repeat (2) tick();
    check("err_still", bus.rf_err, 1'b1);

    // Reset during beat 4 discards the partial line
    d_start = 1; d_ridx = 7'd30;
    tick();
    d_start = 0;
    for (int i = 0; i < 5; i++) begin
      d_bvalid = 1; d_bdata = $urandom; d_last = 0;
      d_resetn = (i != 4);
      tick();
    end
    idle_inputs();
    repeat (BLOCK + 2) begin
      d_bvalid = 1; d_bdata = $urandom;
      tick();
    end
    check("midreset_busy", bus.rf_busy, 1'b0);
    check("midreset_err", bus.rf_err, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      d_resetn = ($urandom_range(0, 299) != 0);
      d_svalid = $urandom_range(0, 1);
      d_sidx   = 7'($urandom_range(0, 15));
      d_soff   = 3'($urandom);
      d_wstrb  = 4'($urandom);
      d_sdata  = $urandom;
      d_start  = ($urandom_range(0, 7) == 0);
      d_ridx   = 7'($urandom_range(0, 15));
      d_bvalid = ($urandom_range(0, 9) < 6);
      d_bdata  = $urandom;
      d_last   = (m_beats.size() == BLOCK - 1) ^ ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
